// File: rtl/fifo_n2w_pkg.sv
// Shared constants and geometry helpers for the narrow-to-wide FIFO.
// The optional flush/keep feature is enabled with FIFO_N2W_FLUSH_EN.
package fifo_n2w_pkg;

    localparam int DEF_IN_W     = 8;
    localparam int DEF_RATIO    = 4;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_AF_LEVEL = 12;

    function automatic int calc_out_w(input int in_w, input int ratio);
        return in_w * ratio;
    endfunction

    function automatic int calc_rows(input int depth, input int ratio);
        return depth / ratio;
    endfunction

    function automatic int calc_lane_w(input int ratio);
        return $clog2(ratio);
    endfunction

    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_n2w_mem.sv
// Row storage for fifo_n2w: per-lane write enables, registered whole-row read.
// With FIFO_N2W_FLUSH_EN a per-lane keep column is stored beside the data.
module fifo_n2w_mem
    import fifo_n2w_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO,
    parameter int ROWS  = calc_rows(DEF_DEPTH, DEF_RATIO),
    localparam int OUT_W = calc_out_w(IN_W, RATIO),
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [RATIO-1:0]   lane_we,
    input  logic [ROW_W-1:0]   wr_row,
    input  logic [OUT_W-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [ROW_W-1:0]   rd_row,
    output logic [OUT_W-1:0]   rd_data
`ifdef FIFO_N2W_FLUSH_EN
    ,
    input  logic [RATIO-1:0]   keep_wdata,
    output logic [RATIO-1:0]   rd_keep
`endif
);

    logic [OUT_W-1:0] mem [ROWS];

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RATIO; i++) begin
            if (lane_we[i]) begin
                mem[wr_row][i*IN_W +: IN_W] <= wr_data[i*IN_W +: IN_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_row];
        end
    end

`ifdef FIFO_N2W_FLUSH_EN
    logic [RATIO-1:0] keep_mem [ROWS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < RATIO; i++) begin
            if (lane_we[i]) begin
                keep_mem[wr_row][i] <= keep_wdata[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_keep <= '0;
        end else if (rd_en) begin
            rd_keep <= keep_mem[rd_row];
        end
    end
`endif

endmodule

// File: rtl/fifo_n2w.sv
// Narrow-to-wide width-converting FIFO: RATIO input words pack into one output row,
// lane 0 (oldest) in the LSBs. Define FIFO_N2W_FLUSH_EN for flush/rd_keep support.
module fifo_n2w
    import fifo_n2w_pkg::*;
#(
    parameter int IN_W     = DEF_IN_W,
    parameter int RATIO    = DEF_RATIO,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [IN_W-1:0]               wr_data,
    output logic                          full,
    output logic                          almost_full,
    input  logic                          rd_en,
    output logic [IN_W*RATIO-1:0]         rd_data,
    output logic                          rd_valid,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          overflow,
    output logic                          underflow
`ifdef FIFO_N2W_FLUSH_EN
    ,
    input  logic                          flush,
    output logic [RATIO-1:0]              rd_keep
`endif
);

    localparam int OUT_W  = calc_out_w(IN_W, RATIO);
    localparam int ROWS   = calc_rows(DEPTH, RATIO);
    localparam int LANE_W = calc_lane_w(RATIO);
    localparam int PTR_W  = calc_ptr_w(DEPTH);
    localparam int ROW_W  = PTR_W - LANE_W;
    localparam int LVL_W  = PTR_W + 1;

    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] RATIO_L = LVL_W'(RATIO);
    localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_LEVEL);

    logic [PTR_W-1:0]  wr_ptr;
    logic [ROW_W-1:0]  wr_row;
    logic [LANE_W-1:0] wr_lane;
    logic [ROW_W-1:0]  rd_row;
    logic              wr_acc;
    logic              rd_acc;
    logic [RATIO-1:0]  lane_we;
    logic [OUT_W-1:0]  row_wdata;
    logic [RATIO-1:0]  keep_wdata;
    logic              flush_pad;
    logic [LVL_W-1:0]  pad_words;
    logic [LVL_W-1:0]  level_next;

    assign wr_row  = wr_ptr[PTR_W-1:LANE_W];
    assign wr_lane = wr_ptr[LANE_W-1:0];

    // Flags depend on the registered level only, so same-cycle traffic never bypasses them.
    assign full        = (level == DEPTH_L);
    assign empty       = (level < RATIO_L);
    assign almost_full = (level >= AF_L);
    assign wr_acc      = wr_en && !full;
    assign rd_acc      = rd_en && !empty;

`ifdef FIFO_N2W_FLUSH_EN
    localparam int LA_W = LANE_W + 1;
    logic [LA_W-1:0] lane_after;

    // Lane position after this cycle's write; padding covers lanes from here to the row end.
    assign lane_after = {1'b0, wr_lane} + LA_W'(wr_acc);
    assign flush_pad  = flush && (lane_after != '0) && (lane_after != LA_W'(RATIO));
    assign pad_words  = flush_pad ? (RATIO_L - LVL_W'(lane_after)) : '0;
`else
    assign flush_pad  = 1'b0;
    assign pad_words  = '0;
`endif

    always_comb begin
        lane_we    = '0;
        row_wdata  = '0;
        keep_wdata = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (wr_acc && (wr_lane == LANE_W'(i))) begin
                lane_we[i]                 = 1'b1;
                row_wdata[i*IN_W +: IN_W]  = wr_data;
                keep_wdata[i]              = 1'b1;
            end
`ifdef FIFO_N2W_FLUSH_EN
            if (flush_pad && (LA_W'(i) >= lane_after)) begin
                lane_we[i] = 1'b1;
            end
`endif
        end
    end

    assign level_next = level + LVL_W'(wr_acc) - (rd_acc ? RATIO_L : '0) + pad_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_row    <= '0;
            level     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            level    <= level_next;
            rd_valid <= rd_acc;
            if (flush_pad) begin
                wr_ptr <= {wr_row + ROW_W'(1), LANE_W'(0)};
            end else if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_row <= rd_row + ROW_W'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_n2w_mem #(
        .IN_W  (IN_W),
        .RATIO (RATIO),
        .ROWS  (ROWS)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .lane_we    (lane_we),
        .wr_row     (wr_row),
        .wr_data    (row_wdata),
        .rd_en      (rd_acc),
        .rd_row     (rd_row),
        .rd_data    (rd_data)
`ifdef FIFO_N2W_FLUSH_EN
        ,
        .keep_wdata (keep_wdata),
        .rd_keep    (rd_keep)
`endif
    );

`ifndef FIFO_N2W_FLUSH_EN
    logic unused_keep;
    assign unused_keep = ^keep_wdata;
`endif

endmodule

// File: tb/tb_fifo_n2w.sv
// Directed self-checking bench for fifo_n2w at default parameters.
// The flush/keep section is compiled when FIFO_N2W_FLUSH_EN is defined.
module tb_fifo_n2w;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        full;
    logic        almost_full;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic        underflow;
`ifdef FIFO_N2W_FLUSH_EN
    logic        flush;
    logic [3:0]  rd_keep;
`endif

    int vectors     = 0;
    int miscompares = 0;

    fifo_n2w dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
`ifdef FIFO_N2W_FLUSH_EN
        ,
        .flush       (flush),
        .rd_keep     (rd_keep)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          model;
        int          rdk;
        bit          wacc;
        bit          racc;
        logic [31:0] e;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
`ifdef FIFO_N2W_FLUSH_EN
        flush   = 1'b0;
`endif
        tick();
        tick();
        check("rst_rd_data",     rd_data,     32'h0);
        check("rst_rd_valid",    rd_valid,    1'b0);
        check("rst_level",       level,       5'd0);
        check("rst_empty",       empty,       1'b1);
        check("rst_full",        full,        1'b0);
        check("rst_almost_full", almost_full, 1'b0);
        check("rst_overflow",    overflow,    1'b0);
        check("rst_underflow",   underflow,   1'b0);
        rst = 1'b0;
        tick();

        // Read from empty: underflow only
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("udf_flag",     underflow, 1'b1);
        check("udf_rd_valid", rd_valid,  1'b0);
        check("udf_rd_data",  rd_data,   32'h0);
        check("udf_level",    level,     5'd0);

        // Asynchronous reset clears sticky flag without a clock edge
        #2 rst = 1'b1;
        #1;
        check("async_rst_udf", underflow, 1'b0);
        rst = 1'b0;
        tick();

        // Basic pack of four bytes
        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        check("basic_level3", level, 5'd3);
        check("basic_empty3", empty, 1'b1);
        wr_byte(8'h44);
        check("basic_level4", level, 5'd4);
        check("basic_empty4", empty, 1'b0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("basic_rd_valid", rd_valid, 1'b1);
        check("basic_rd_data",  rd_data,  32'h44332211);
        check("basic_level0",   level,    5'd0);
        check("basic_empty",    empty,    1'b1);
        tick();
        check("basic_valid_pulse", rd_valid, 1'b0);
        check("basic_data_hold",   rd_data,  32'h44332211);

        // Fill to full, almost_full threshold, overflow
        for (int i = 0; i < 16; i++) begin
            wr_byte(8'(8'h50 + i));
            if (i == 10) check("af_at_11",   almost_full, 1'b0);
            if (i == 11) check("af_at_12",   almost_full, 1'b1);
            if (i == 14) check("full_at_15", full,        1'b0);
        end
        check("full_level", level, 5'd16);
        check("full_flag",  full,  1'b1);
        wr_byte(8'hEE);
        check("ovf_level", level,    5'd16);
        check("ovf_flag",  overflow, 1'b1);
        check("ovf_udf",   underflow, 1'b0);
        for (int r = 0; r < 4; r++) begin
            rd_en = 1'b1;
            tick();
            e = {8'(8'h53 + 4*r), 8'(8'h52 + 4*r), 8'(8'h51 + 4*r), 8'(8'h50 + 4*r)};
            check("full_rd_valid", rd_valid, 1'b1);
            check("full_rd_data",  rd_data,  e);
        end
        rd_en = 1'b0;
        check("full_drain_level", level,    5'd0);
        check("ovf_sticky",       overflow, 1'b1);

        // Simultaneous read and write
        do_reset();
        check("rst_clears_ovf", overflow, 1'b0);
        for (int i = 1; i <= 5; i++) wr_byte(8'(i));
        check("sim_level5", level, 5'd5);
        wr_en   = 1'b1;
        wr_data = 8'h06;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("sim_level",    level,     5'd2);
        check("sim_rd_valid", rd_valid,  1'b1);
        check("sim_rd_data",  rd_data,   32'h04030201);
        check("sim_ovf",      overflow,  1'b0);
        check("sim_udf",      underflow, 1'b0);
        wr_byte(8'h07);
        // Write at level 3 does not enable a read in the same cycle
        wr_en   = 1'b1;
        wr_data = 8'h08;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("nobypass_level", level,     5'd4);
        check("nobypass_valid", rd_valid,  1'b0);
        check("nobypass_udf",   underflow, 1'b1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("nobypass_rd_data", rd_data, 32'h08070605);

        // Reset while a read result is presented
        for (int i = 0; i < 4; i++) wr_byte(8'(8'hC0 + i));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("midrst_pre_valid", rd_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", rd_valid,  1'b0);
        check("midrst_data",  rd_data,   32'h0);
        check("midrst_level", level,     5'd0);
        check("midrst_empty", empty,     1'b1);
        check("midrst_udf",   underflow, 1'b0);
        rst = 1'b0;
        tick();

        // Stream 40 bytes with interleaved reads across pointer wrap
        model = 0;
        rdk   = 0;
        for (int i = 0; i < 44; i++) begin
            wr_en   = (i < 40);
            wr_data = 8'(8'h80 + i);
            rd_en   = ((i % 4) == 3 && i >= 7) || (i >= 40);
            wacc    = wr_en && (model < 16);
            racc    = rd_en && (model >= 4);
            tick();
            model = model + int'(wacc) - (racc ? 4 : 0);
            check("wrap_level", level, model);
            if (racc) begin
                e = {8'(8'h83 + 4*rdk), 8'(8'h82 + 4*rdk), 8'(8'h81 + 4*rdk), 8'(8'h80 + 4*rdk)};
                check("wrap_rd_valid", rd_valid, 1'b1);
                check("wrap_rd_data",  rd_data,  e);
                rdk++;
            end else begin
                check("wrap_rd_idle", rd_valid, 1'b0);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("wrap_end_empty", empty,     1'b1);
        check("wrap_end_level", level,     5'd0);
        check("wrap_end_udf",   underflow, 1'b1);

`ifdef FIFO_N2W_FLUSH_EN
        do_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_noop_level", level, 5'd0);
        wr_byte(8'hAA);
        wr_byte(8'hBB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_level", level, 5'd4);
        check("flush_empty", empty, 1'b0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("flush_rd_valid", rd_valid, 1'b1);
        check("flush_rd_data",  rd_data,  32'h0000BBAA);
        check("flush_rd_keep",  rd_keep,  4'b0011);
        wr_byte(8'hCC);
        wr_en   = 1'b1;
        wr_data = 8'hDD;
        flush   = 1'b1;
        tick();
        wr_en = 1'b0;
        flush = 1'b0;
        check("flushwr_level", level, 5'd4);
        for (int i = 0; i < 4; i++) wr_byte(8'(8'h10 + i));
        rd_en = 1'b1;
        tick();
        check("flushwr_rd_data", rd_data, 32'h0000DDCC);
        check("flushwr_rd_keep", rd_keep, 4'b0011);
        tick();
        rd_en = 1'b0;
        check("flushfull_rd_data", rd_data, 32'h13121110);
        check("flushfull_rd_keep", rd_keep, 4'b1111);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
